// File: rtl/fabric_fle_param.sv
// Fracturable logic element: NUM_OUT LUT slices sharing NUM_IN inputs, each with
// an optional output flip-flop (clock enable, synchronous set/reset to an init
// value). Configuration is a serial scan chain shifted on the user clock; a
// shift counter reports whether exactly one full chain length was loaded.
module fabric_fle_param #(
  parameter int NUM_IN  = 4,
  parameter int NUM_OUT = 2
) (
  input  logic               clk,
  input  logic               pReset,
  input  logic               prog_en,
  input  logic               ccff_head,
  input  logic [NUM_IN-1:0]  fabric_in,
  input  logic               fabric_ce,
  input  logic               fabric_sr,
  output logic [NUM_OUT-1:0] fabric_out,
  output logic               ccff_tail,
  output logic               cfg_loaded
);

  localparam int LUT_SIZE   = 2 ** NUM_IN;
  localparam int SLICE_BITS = LUT_SIZE + 3;
  localparam int CFG_BITS   = NUM_OUT * SLICE_BITS;
  localparam int CNT_W      = $clog2(CFG_BITS + 2);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CFG_BITS-1:0] chain_r;
  logic [CNT_W-1:0]    shift_cnt_r;
  logic                prog_en_d_r;
  logic [NUM_OUT-1:0]  ff_r;

  logic [NUM_OUT-1:0]  lut_s;
  logic [NUM_OUT-1:0]  reg_sel_s;
  logic [NUM_OUT-1:0]  ff_init_s;
  logic [NUM_OUT-1:0]  ce_use_s;
  logic [NUM_OUT-1:0]  out_s;

  // Per-slice decode of configuration fields and LUT lookup.
  for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_slice
    localparam int BASE = gi * SLICE_BITS;
    logic [LUT_SIZE-1:0] tt_s;
    assign tt_s          = chain_r[BASE +: LUT_SIZE];
    assign lut_s[gi]     = tt_s[fabric_in];
    assign reg_sel_s[gi] = chain_r[BASE + LUT_SIZE];
    assign ff_init_s[gi] = chain_r[BASE + LUT_SIZE + 1];
    assign ce_use_s[gi]  = chain_r[BASE + LUT_SIZE + 2];
  end

  // Configuration scan chain: shift toward the tail while programming.
  always_ff @(posedge clk or negedge pReset) begin
    if (!pReset) begin
      chain_r <= '0;
    end else if (prog_en) begin
      chain_r <= {chain_r[CFG_BITS-2:0], ccff_head};
    end else begin
      chain_r <= chain_r;
    end
  end

  // Previous-cycle prog_en, used for rise detection and the init load.
  always_ff @(posedge clk or negedge pReset) begin
    if (!pReset) begin
      prog_en_d_r <= 1'b0;
    end else begin
      prog_en_d_r <= prog_en;
    end
  end

  // Shift counter: restarts at 1 on the rising edge of prog_en, saturates one past full.
  always_ff @(posedge clk or negedge pReset) begin
    if (!pReset) begin
      shift_cnt_r <= '0;
    end else if (prog_en) begin
      if (!prog_en_d_r) begin
        shift_cnt_r <= CNT_ONE;
      end else if (shift_cnt_r < CNT_SAT) begin
        shift_cnt_r <= shift_cnt_r + CNT_ONE;
      end else begin
        shift_cnt_r <= shift_cnt_r;
      end
    end else begin
      shift_cnt_r <= shift_cnt_r;
    end
  end

  // Slice flip-flops: hold while programming, init load on exit, then sr > ce > hold.
  always_ff @(posedge clk or negedge pReset) begin
    if (!pReset) begin
      ff_r <= '0;
    end else if (prog_en) begin
      ff_r <= ff_r;
    end else if (prog_en_d_r) begin
      ff_r <= ff_init_s;
    end else begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (fabric_sr) begin
          ff_r[i] <= ff_init_s[i];
        end else if (!ce_use_s[i] || fabric_ce) begin
          ff_r[i] <= lut_s[i];
        end else begin
          ff_r[i] <= ff_r[i];
        end
      end
    end
  end

  // Output select per slice, gated to zero while the chain is being programmed.
  always_comb begin
    out_s = '0;
    if (prog_en) begin
      out_s = '0;
    end else begin
      out_s = (reg_sel_s & ff_r) | (~reg_sel_s & lut_s);
    end
  end

  assign fabric_out = out_s;
  assign ccff_tail  = chain_r[CFG_BITS-1];
  assign cfg_loaded = (shift_cnt_r == CNT_FULL) & ~prog_en;

endmodule

// File: tb/tb_fabric_fle_param.sv
// Testbench for fabric_fle_param (NUM_IN=4, NUM_OUT=2, 38-bit chain).
// Stimulus pushes expected outputs into a queue; a monitor on the falling
// clock edge pops and compares them against the DUT.
module tb_fabric_fle_param;

  logic       clk;
  logic       pReset;
  logic       prog_en;
  logic       ccff_head;
  logic [3:0] fabric_in;
  logic       fabric_ce;
  logic       fabric_sr;
  logic [1:0] fabric_out;
  logic       ccff_tail;
  logic       cfg_loaded;

  fabric_fle_param #(.NUM_IN(4), .NUM_OUT(2)) dut (
    .clk        (clk),
    .pReset     (pReset),
    .prog_en    (prog_en),
    .ccff_head  (ccff_head),
    .fabric_in  (fabric_in),
    .fabric_ce  (fabric_ce),
    .fabric_sr  (fabric_sr),
    .fabric_out (fabric_out),
    .ccff_tail  (ccff_tail),
    .cfg_loaded (cfg_loaded)
  );

  typedef struct packed {
    logic [2:0] mask;   // [2]=out, [1]=loaded, [0]=tail
    logic [1:0] out;
    logic       loaded;
    logic       tail;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks;
  int    n_errors;

  // Slice0: AND4 combinational. Slice1: XOR4 registered, init 0, no ce.
  localparam logic [37:0] CFG_A = {1'b0, 1'b0, 1'b1, 16'h6996, 1'b0, 1'b0, 1'b0, 16'h8000};
  // Slice0: AND4 registered, init 0, ce_use. Slice1: XOR4 registered, init 1, ce_use.
  localparam logic [37:0] CFG_B = {1'b1, 1'b1, 1'b1, 16'h6996, 1'b1, 1'b0, 1'b1, 16'h8000};
  localparam logic [37:0] PAT_1 = 38'h2BC5A396E1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] mask, input logic [1:0] out,
                      input logic loaded, input logic tail, input string name);
    exp_t e;
    e.mask   = mask;
    e.out    = out;
    e.loaded = loaded;
    e.tail   = tail;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic load(input logic [37:0] c, input int nbits);
    int idx;
    for (int k = 0; k < nbits; k++) begin
      idx       = 37 - k;
      prog_en   = 1'b1;
      ccff_head = (idx >= 0) ? c[idx] : 1'b0;
      tick();
    end
    prog_en   = 1'b0;
    ccff_head = 1'b0;
  endtask

  // Monitor: compare every queued expectation away from the active edge.
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (e.mask[2]) begin
        n_checks++;
        if (fabric_out !== e.out) begin
          n_errors++;
          $display("FAIL %s fabric_out got=%b exp=%b", nm, fabric_out, e.out);
        end
      end
      if (e.mask[1]) begin
        n_checks++;
        if (cfg_loaded !== e.loaded) begin
          n_errors++;
          $display("FAIL %s cfg_loaded got=%b exp=%b", nm, cfg_loaded, e.loaded);
        end
      end
      if (e.mask[0]) begin
        n_checks++;
        if (ccff_tail !== e.tail) begin
          n_errors++;
          $display("FAIL %s ccff_tail got=%b exp=%b", nm, ccff_tail, e.tail);
        end
      end
    end
  end

  // Directed tables: input, ce, sr, expected {out1,out0} before the next edge.
  logic [3:0] a_in  [8] = '{4'hF, 4'hE, 4'h7, 4'h0, 4'h1, 4'hF, 4'h8, 4'h3};
  logic [1:0] a_exp [8] = '{2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b11, 2'b00, 2'b10};

  logic [3:0] b_in  [9] = '{4'h0, 4'hF, 4'hF, 4'h7, 4'h1, 4'h1, 4'hE, 4'hF, 4'h0};
  logic       b_ce  [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic       b_sr  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [1:0] b_exp [9] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01};

  task automatic run_table_a(input string tag);
    for (int i = 0; i < 8; i++) begin
      fabric_in = a_in[i];
      fabric_ce = 1'b0;
      fabric_sr = 1'b0;
      push(3'b100, a_exp[i], 1'b0, 1'b0, tag);
      tick();
    end
  endtask

  initial begin
    int wait_cnt;
    n_checks  = 0;
    n_errors  = 0;
    pReset    = 1'b0;
    prog_en   = 1'b0;
    ccff_head = 1'b0;
    fabric_in = 4'h0;
    fabric_ce = 1'b0;
    fabric_sr = 1'b0;

    push(3'b111, 2'b00, 1'b0, 1'b0, "reset");
    tick();
    tick();
    pReset = 1'b1;
    tick();

    // Full-length load of a known pattern.
    load(PAT_1, 38);
    push(3'b011, 2'b00, 1'b1, PAT_1[37], "load38");
    tick();

    // Second pass echoes the first pattern on the tail while loading CFG_A.
    for (int k = 0; k < 38; k++) begin
      prog_en   = 1'b1;
      ccff_head = CFG_A[37 - k];
      push(3'b111, 2'b00, 1'b0, PAT_1[37 - k], "echo");
      tick();
    end
    prog_en   = 1'b0;
    ccff_head = 1'b0;
    push(3'b011, 2'b00, 1'b1, CFG_A[37], "load_a");
    tick();
    run_table_a("tbl_a");

    // Mis-length loads.
    load(PAT_1, 37);
    push(3'b010, 2'b00, 1'b0, 1'b0, "short37");
    tick();
    load(PAT_1, 39);
    push(3'b010, 2'b00, 1'b0, 1'b0, "long39");
    tick();

    // Registered slices with clock enable and synchronous set/reset.
    load(CFG_B, 38);
    push(3'b010, 2'b00, 1'b1, 1'b0, "load_b");
    tick();
    for (int i = 0; i < 9; i++) begin
      fabric_in = b_in[i];
      fabric_ce = b_ce[i];
      fabric_sr = b_sr[i];
      push(3'b100, b_exp[i], 1'b0, 1'b0, "tbl_b");
      tick();
    end
    fabric_ce = 1'b0;
    fabric_sr = 1'b0;

    // Re-raising prog_en gates outputs and drops cfg_loaded at once.
    prog_en   = 1'b1;
    fabric_in = 4'hF;
    push(3'b110, 2'b00, 1'b0, 1'b0, "reprog");
    tick();
    prog_en = 1'b0;
    tick();

    // Reset in the middle of a load, then full reload.
    load(CFG_A, 20);
    pReset = 1'b0;
    push(3'b111, 2'b00, 1'b0, 1'b0, "rst_mid");
    tick();
    pReset = 1'b1;
    push(3'b011, 2'b00, 1'b0, 1'b0, "after_rst");
    tick();
    load(CFG_A, 38);
    push(3'b010, 2'b00, 1'b1, 1'b0, "reload_a");
    tick();
    run_table_a("tbl_a2");

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      tick();
      wait_cnt++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog time=%0t limit=200000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fabric_fle_param.md
Name: fabric_fle_param

Overview:
- Parametrised fracturable logic element: NUM_OUT independent LUTs, each with an optional output flip-flop and a registered/combinational output select.
- Configuration is held in an internal scan chain (ccff_head/ccff_tail), shifted on the same clock as user logic.
- Adds functions the fixed 4-in/2-out fabric lacks: FF clock enable, synchronous set/reset to a configured init value, and a load-complete flag.
- Instantiated per fle inside the clb logical tile; chains daisy-chain through ccff_head/ccff_tail.

Parameters:
- NUM_IN, 4, LUT inputs shared by all outputs (2..6).
- NUM_OUT, 2, number of LUT/FF/output slices (1..8).
- SLICE_BITS, 2**NUM_IN+3, derived (localparam): config bits per slice.
- CFG_BITS, NUM_OUT*SLICE_BITS, derived (localparam): total chain length.

Ports:
- clk  in  1  single clock for config shift and user FFs
- pReset  in  1  asynchronous reset, active-low
- prog_en  in  1  1 = shift config chain, 0 = run
- ccff_head  in  1  serial config in
- fabric_in  in  NUM_IN  LUT address; fabric_in[0] is LSB
- fabric_ce  in  1  FF clock enable, honoured only where slice ce_use=1
- fabric_sr  in  1  synchronous set/reset: FFs load ff_init
- fabric_out  out  NUM_OUT  slice outputs
- ccff_tail  out  1  serial config out = chain[CFG_BITS-1]
- cfg_loaded  out  1  exactly CFG_BITS shifts seen since reset or last prog_en rise, and prog_en=0

Behaviour:
- Reset (pReset=0, asynchronous): chain all 0; all FFs 0; shift counter 0; cfg_loaded 0; fabric_out 0; ccff_tail 0.
- Chain layout:
  - Each clk with prog_en=1: chain[0]<=ccff_head, chain[j]<=chain[j-1].
  - Slice i base b=i*SLICE_BITS.
  - chain[b +: 2**NUM_IN] = truth table; entry index = fabric_in value.
  - chain[b+2**NUM_IN] = reg_sel.
  - chain[b+2**NUM_IN+1] = ff_init.
  - chain[b+2**NUM_IN+2] = ce_use.
  - First bit shifted lands in chain[CFG_BITS-1] after CFG_BITS shifts.
- Shift counter:
  - Cleared on the clk where prog_en rises (0->1); that cycle's shift counts as 1.
  - Increments per shift, saturating at CFG_BITS+1; any count != CFG_BITS means a mis-length load.
  - Chain contents are not cleared on prog_en rise.
- cfg_loaded: combinational = (count==CFG_BITS) & ~prog_en. Re-asserting prog_en drops it immediately.
- While prog_en=1:
  - fabric_out forced to 0 (combinational gating).
  - FFs hold their value; fabric_ce and fabric_sr are ignored.
- Init load: on the first clk with prog_en=0 following a cycle with prog_en=1, every FF i loads its ff_init. fabric_ce and fabric_sr are ignored that cycle.
- Run mode, per slice i, per clk, priority high to low:
  - fabric_sr=1 -> ff_q[i]<=ff_init.
  - ce_use=0 or fabric_ce=1 -> ff_q[i]<=lut_out[i].
  - Otherwise hold.
- lut_out[i] = truth_table_i[fabric_in], purely combinational.
- fabric_out[i] = reg_sel ? ff_q[i] : lut_out[i].
  - Combinational path: 0 cycles latency.
  - Registered path: 1 cycle latency.
- pReset asserted mid-shift: chain and counter cleared at once; cfg_loaded stays 0 until a full reload.
- Simultaneous fabric_sr=1 and fabric_ce=0 with ce_use=1: sr wins, FF loads ff_init.

Test Plan (NUM_IN=4, NUM_OUT=2, CFG_BITS=38):
- Reset then 38 shifts of a known pattern, prog_en low -> cfg_loaded=1. Another 38 shifts echo the first pattern on ccff_tail starting at shift 1.
- Load 37 bits then drop prog_en -> cfg_loaded=0. Load 39 bits -> cfg_loaded=0.
- Slice0 = AND4 (truth table 0x8000), reg_sel=0 -> fabric_out[0]=1 in the same cycle only for fabric_in=4'hF. Slice1 = XOR4 (0x6996), reg_sel=1 -> fabric_out[1] follows parity one clk later.
- Slice1 ce_use=1, ff_init=1 -> after prog_en falls, fabric_out[1]=1. With fabric_ce=0 it holds through input changes; fabric_ce=1 updates next clk.
- fabric_sr=1 with fabric_ce=0 -> both FFs load ff_init next clk. Re-raise prog_en -> fabric_out=0 immediately.
- pReset pulsed low mid-load at shift 20 -> fabric_out, ccff_tail, cfg_loaded=0 asynchronously. A full 38-bit reload restores correct function.
